// File: rtl/run_stream_tx.sv
// Run-length serial transmitter: expands (bit, length) commands into a gapless bit stream
// and predicts the downstream run detector's "MATCH_N identical bits" indication.
module run_stream_tx #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned MATCH_N = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_bit_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             out_o,
  output logic             out_valid_o,
  output logic             run_done_o,
  output logic             match_o,
  output logic             busy_o,
  output logic             state_dout_o
);

  localparam int unsigned StreakW = $clog2(MATCH_N) + 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MATCH_N);
  localparam logic [StreakW-1:0] StreakOne = StreakW'(1);
  localparam logic [LEN_W-1:0]   CntOne    = LEN_W'(1);

  typedef enum logic {StIdle = 1'b0, StSend = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 cur_bit_q, cur_bit_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic                 out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 run_done_q, run_done_d;
  logic                 match_q, match_d;
  logic                 accept;
  logic                 load;

  assign cmd_ready_o = (state_q == StIdle) || (cnt_q == CntOne);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign load        = accept && (cmd_len_i != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_bit_d   = cur_bit_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    run_done_d  = 1'b0;
    streak_d    = '0;
    match_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Zero-length commands are consumed here without leaving IDLE.
        if (load) begin
          state_d   = StSend;
          cnt_d     = cmd_len_i;
          cur_bit_d = cmd_bit_i;
        end
      end
      StSend: begin
        if (cnt_q != CntOne) begin
          cnt_d = cnt_q - CntOne;
        end else if (load) begin
          cnt_d     = cmd_len_i;
          cur_bit_d = cmd_bit_i;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
    endcase

    if (state_d == StSend) begin
      out_valid_d = 1'b1;
      out_d       = cur_bit_d;
      run_done_d  = (cnt_d == CntOne);
    end

    // A gap cycle or a value change restarts the streak.
    if (out_valid_d) begin
      if (out_valid_q && (out_d == out_q)) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + StreakOne;
      end else begin
        streak_d = StreakOne;
      end
    end
    match_d = out_valid_d && (streak_d == StreakMax);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cur_bit_q   <= 1'b0;
      streak_q    <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      run_done_q  <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_bit_q   <= cur_bit_d;
      streak_q    <= streak_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      run_done_q  <= run_done_d;
      match_q     <= match_d;
    end
  end

  assign out_o        = out_q;
  assign out_valid_o  = out_valid_q;
  assign run_done_o   = run_done_q;
  assign match_o      = match_q;
  assign busy_o       = (state_q == StSend);
  assign state_dout_o = state_q;

endmodule

// File: doc/run_stream_tx.md
# run_stream_tx

Serial run-length transmitter: accepts commands of the form (bit value, run length) over a valid/ready handshake and serialises each as `len` consecutive copies of the bit, one per clock, on a single-bit stream. It is the source end of the serial-pattern path: its `out` drives the `in` of the run detector FSM. It also produces `match`, a registered prediction of the detector's "four or more identical bits" indication, which benches use as the reference model. Back-to-back commands stream with no gap cycles.

## Interface
- `LEN_W`, default 4: width of the run-length field; maximum run is 2^LEN_W − 1 bits.
- `MATCH_N`, default 4: consecutive-identical-bit count at which `match` asserts.

- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_bit` input 1: bit value to repeat.
- `cmd_len` input LEN_W: number of bits to emit (0 = drop command).
- `out` output 1: serial data bit, registered.
- `out_valid` output 1: `out` carries a run bit this cycle, registered.
- `run_done` output 1: high with the last bit of each run, registered.
- `match` output 1: current bit is the MATCH_N-th or later consecutive identical valid bit, registered.
- `busy` output 1: state is SEND.
- `state_dout` output 1: current state (0 = IDLE, 1 = SEND) for debug/bench.

## Operation
- Registers: `state`, `cnt` (LEN_W, bits remaining including current), `cur_bit`, `streak` (saturating at MATCH_N, width clog2(MATCH_N)+1), plus the registered outputs.
- `cmd_ready = (state == IDLE) || (cnt == 1)` is combinational from registers only and never depends on `cmd_valid`.
- IDLE: `out_valid = 0`, `out = 0`, `streak = 0`.
  - On accept with `cmd_len != 0`, go to SEND with `cnt = cmd_len` and `out = cmd_bit`.
  - On accept with `cmd_len == 0`, consume the command and stay in IDLE. No output bit and no `run_done`.
- SEND: each cycle emits `out = cur_bit` with `out_valid = 1`.
  - When `cnt > 1`, decrement `cnt`.
  - When `cnt == 1`, this is the last bit and `run_done = 1`.
    - If a nonzero-length command is accepted on this edge, load it. The next cycle is its first bit, with no gap.
    - If a zero-length command is accepted, or no command is accepted, go to IDLE.
- Streak, computed when each valid bit is registered:
  - Next bit valid and equal to the previous valid bit with no gap cycle in between: `streak = min(streak + 1, MATCH_N)`.
  - Next bit valid but a different value, or the previous cycle was not valid: `streak = 1`.
  - Next cycle not valid: `streak = 0`.
- `match = out_valid && (streak == MATCH_N)`, evaluated on the registered values so that it aligns with `out`.
- Streaks continue across back-to-back runs of the same bit value. Any idle cycle breaks the streak.
- `busy = (state == SEND)`. `state_dout` mirrors `state`.

## Timing
- Reset low (asynchronous) drives immediately: state = IDLE, cnt = 0, streak = 0, out = 0, out_valid = 0, run_done = 0, match = 0, busy = 0, state_dout = 0.
  - As a result, `cmd_ready = 1` while in reset.
- Reset asserted mid-run aborts the run immediately. No further bits are emitted and the pending command is lost.
- Latency: a command accepted at edge k produces its first bit (`out_valid = 1`) in the cycle after edge k, and its last bit in the cycle after edge k + len − 1.
- Back-to-back: a command accepted on the last-bit edge starts in the next cycle, so `out_valid` stays high continuously.
- `run_done` is high for exactly one cycle per nonzero run, coincident with that run's last bit.
- `match` is coincident with the bit it qualifies. The detector's Moore output lags its input by one cycle, so the bench compares the detector output against `match` delayed by one cycle.
- When `cmd_valid` is low, the next command is simply not accepted. `cmd_valid` may drop at any time before acceptance; the command fields are sampled only on the accept edge.

## Test plan
- Reset mid-run: (1,7) accepted, then reset low on bit 3 → out, out_valid, match and run_done go 0 at once; after release, IDLE with cmd_ready = 1 and no residual bits.
- Single run: (1,3), then idle → out = 1,1,1 with out_valid high for 3 cycles; run_done on cycle 3; match never high; back to IDLE.
- Long run: (0,6) → six 0 bits; match high on bits 4, 5 and 6; run_done on bit 6.
- Gapless same-value runs: (1,2) accepted on the last-bit edge of a prior run, then (1,3) → five continuous 1s; match on bits 4 and 5; run_done on bits 2 and 5.
- Value change: back-to-back (0,4), (1,4) → match on bit 4 and bit 8 only (the streak resets at bit 5).
- Gap and zero length: (1,3), one idle cycle, (0,0) accepted with no output, then (1,2) → match never high; only two run_done pulses.
